// File: rtl/mem_arbiter.sv
// Two-port round-robin read arbiter in front of a single-outstanding memory.
// Optional WAIT watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic              rdy0,
    output logic              rdy1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_data_ready,
    input  logic [DATA_W-1:0] mem_data,
    output logic              busy
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT_CYCLES must be 1..255");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t state;
    logic   grant;
    logic   last;
    logic   pick;

    // On a tie the port that was not served last wins
    always_comb pick = (req0 & req1) ? ~last : req1;

`ifdef MEM_ARB_TIMEOUT_EN
    logic [7:0] cnt;
    logic       expire;

    always_comb expire = (cnt == 8'(TIMEOUT_CYCLES - 1));
`else
    assign err0 = 1'b0;
    assign err1 = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= 1'b0;
            last     <= 1'b1;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            rdy0     <= 1'b0;
            rdy1     <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
            busy     <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            err0     <= 1'b0;
            err1     <= 1'b0;
            cnt      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        grant    <= pick;
                        mem_addr <= pick ? addr1 : addr0;
                        mem_req  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_req <= 1'b0;
                    state   <= WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
                    cnt     <= '0;
`endif
                end
                WAIT: begin
                    if (mem_data_ready) begin
                        if (grant) begin
                            rdata1 <= mem_data;
                            rdy1   <= 1'b1;
                        end else begin
                            rdata0 <= mem_data;
                            rdy0   <= 1'b1;
                        end
                        state <= RESP;
`ifdef MEM_ARB_TIMEOUT_EN
                    end else if (expire) begin
                        if (grant) begin
                            rdata1 <= '0;
                            rdy1   <= 1'b1;
                            err1   <= 1'b1;
                        end else begin
                            rdata0 <= '0;
                            rdy0   <= 1'b1;
                            err0   <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
`endif
                    end
                end
                RESP: begin
                    rdy0  <= 1'b0;
                    rdy1  <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
                    err0  <= 1'b0;
                    err1  <= 1'b0;
`endif
                    last  <= grant;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
